rd_arbiter: RTL

- Arbitrates N read requesters (IFU, LSU, MMU page-table walker) onto the single downstream AXI read port of the core.
- Fixed-priority selection with an aging override so the low-priority IFU cannot starve.
- One outstanding transaction at a time; a grant is held from AR acceptance until the RLAST beat.
- Sits between the requester read channels and the memory-side read port in the CPU top.

---
 rtl/rd_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rd_arbiter
//  Purpose  : Arbitrates IFU / LSU / MMU read requesters onto the core's
//             single downstream AXI read port. Fixed priority (highest index
//             wins) with an aging override so a starved requester is served.
//             One transaction in flight; the grant spans AR through RLAST.
//  Revision : 1.0  initial release
// ============================================================================
module rd_arbiter #(
    parameter int N          = 3,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req_arvalid,
    output logic [N-1:0]    req_arready,
    input  logic [N*AW-1:0] req_araddr,
    input  logic [N*8-1:0]  req_arlen,
    output logic [N-1:0]    req_rvalid,
    input  logic [N-1:0]    req_rready,
    output logic [DW-1:0]   req_rdata,
    output logic [1:0]      req_rresp,
    output logic            req_rlast,
    output logic            mem_arvalid,
    input  logic            mem_arready,
    output logic [AW-1:0]   mem_araddr,
    output logic [7:0]      mem_arlen,
    input  logic            mem_rvalid,
    output logic            mem_rready,
    input  logic [DW-1:0]   mem_rdata,
    input  logic [1:0]      mem_rresp,
    input  logic            mem_rlast,
    output logic            busy
);

    localparam int         GW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] AGE_MAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] grant;
    logic [GW-1:0] grant_nxt;
    logic [GW-1:0] winner;
    logic [3:0]    age [N];
    logic          ar_fire;
    logic          r_done;

    assign ar_fire = (state == ADDR) && mem_arvalid && mem_arready;
    assign r_done  = (state == DATA) && mem_rvalid && mem_rready && mem_rlast;
    assign busy    = (state != IDLE);

    // Pick the next winner: highest valid index, overridden by the lowest
    // starved index (later loop assignments take precedence).
    always_comb begin
        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (req_arvalid[i]) winner = GW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_arvalid[i] && (age[i] == AGE_MAX)) winner = GW'(i);
        end
    end

    // State and grant registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    // Next-state logic: IDLE picks, ADDR waits for AR handshake, DATA for RLAST.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (|req_arvalid) begin
                    grant_nxt = winner;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (ar_fire) state_nxt = DATA;
            end
            DATA: begin
                if (r_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Channel steering: only the granted requester sees AR/R traffic.
    always_comb begin
        req_arready = '0;
        req_rvalid  = '0;
        req_rdata   = '0;
        req_rresp   = '0;
        req_rlast   = 1'b0;
        mem_arvalid = 1'b0;
        mem_araddr  = '0;
        mem_arlen   = '0;
        mem_rready  = 1'b0;
        case (state)
            ADDR: begin
                mem_arvalid        = req_arvalid[grant];
                mem_araddr         = req_araddr[int'(grant)*AW +: AW];
                mem_arlen          = req_arlen[int'(grant)*8 +: 8];
                req_arready[grant] = mem_arready;
            end
            DATA: begin
                req_rvalid[grant] = mem_rvalid;
                mem_rready        = req_rready[grant];
                req_rdata         = mem_rdata;
                req_rresp         = mem_rresp;
                req_rlast         = mem_rlast;
            end
            default: ;
        endcase
    end

    // Per-requester age: counts waiting cycles, cleared on its AR handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ar_fire && (grant == GW'(i))) begin
                    age[i] <= '0;
                end else if (req_arvalid[i] && !((state != IDLE) && (grant == GW'(i)))
                             && (age[i] != AGE_MAX)) begin
                    age[i] <= age[i] + 4'd1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // A requester that has been granted must keep arvalid until arready.
    ar_hold_chk: assert property (@(posedge clock) disable iff (!reset)
        (state == ADDR) |-> req_arvalid[grant])
        else $error("rd_arbiter: arvalid dropped during address phase");
`endif

endmodule
`default_nettype wire
